// File: rtl/pic_fetch_unit.sv
// pic_fetch_unit: PC sequencing, IR latch and return stack for the 14-bit core.
// Optional define PIC_FETCH_STACK_CHECK_EN adds occupancy tracking and sticky stack flags.
module pic_fetch_unit #(
    parameter int                  PC_WIDTH     = 11,
    parameter int                  STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] Rom_addr_out,
    input  logic [13:0]         Rom_data_in,
    input  logic                stall,
    input  logic                skip_req,
    output logic [13:0]         ir_out,
    output logic                ir_valid,
    output logic [PC_WIDTH-1:0] ir_pc,
    output logic                stack_ovf,
    output logic                stack_unf
);

    localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]     sp;
    logic [SP_W-1:0]     sp_dec;
    logic                is_goto;
    logic                is_call;
    logic                is_ret;
    logic                do_skip;
    logic                flush;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] ret_addr;
    logic [PC_WIDTH-1:0] next_pc;

    assign Rom_addr_out = pc;
    assign sp_dec       = sp - SP_W'(1);
    assign ret_addr     = stack_mem[sp_dec];
    assign target       = PC_WIDTH'(ir_out[10:0]);

    // Decode control transfers from the registered IR and pick the next PC.
    always_comb begin
        is_goto = ir_valid && (ir_out[13:11] == 3'b101);
        is_call = ir_valid && (ir_out[13:11] == 3'b100);
        is_ret  = ir_valid && ((ir_out == 14'h0008) ||
                               (ir_out[13:10] == 4'b1101));
        do_skip = ir_valid && skip_req && !(is_goto || is_call || is_ret);
        flush   = is_goto || is_call || is_ret || do_skip;
        push    = !stall && is_call;
        pop     = !stall && is_ret;
        next_pc = pc + PC_WIDTH'(1);
        unique case (1'b1)
            is_goto: next_pc = target;
            is_call: next_pc = target;
            is_ret:  next_pc = ret_addr;
            default: next_pc = pc + PC_WIDTH'(1);
        endcase
    end

    // Fetch state: PC, instruction register, bubble flag and fetch address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_VECTOR;
            ir_out   <= 14'h0000;
            ir_valid <= 1'b0;
            ir_pc    <= '0;
        end else if (!stall) begin
            pc       <= next_pc;
            ir_out   <= Rom_data_in;
            ir_valid <= !flush;
            ir_pc    <= pc;
        end
    end

    // Circular return stack; pointer wraps freely regardless of occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (push) begin
            stack_mem[sp] <= ir_pc + PC_WIDTH'(1);
            sp            <= sp + SP_W'(1);
        end else if (pop) begin
            sp <= sp_dec;
        end
    end

`ifdef PIC_FETCH_STACK_CHECK_EN
    logic [SP_W:0] occ;
    logic          full;
    logic          empty;

    assign full  = (occ == (SP_W+1)'(STACK_DEPTH));
    assign empty = (occ == '0);

    // Saturating occupancy plus sticky overflow/underflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (push) begin
            if (full) begin
                stack_ovf <= 1'b1;
            end else begin
                occ <= occ + (SP_W+1)'(1);
            end
        end else if (pop) begin
            if (empty) begin
                stack_unf <= 1'b1;
            end else begin
                occ <= occ - (SP_W+1)'(1);
            end
        end
    end
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

endmodule
